// File: rtl/gh_uart_pkg.sv
// Shared types and helpers for the UART transmit path.
package gh_uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  localparam logic [1:0] WLEN_5 = 2'b00;
  localparam logic [1:0] WLEN_6 = 2'b01;
  localparam logic [1:0] WLEN_7 = 2'b10;
  localparam logic [1:0] WLEN_8 = 2'b11;

  function automatic logic [3:0] wlen_to_bits(input logic [1:0] wlen);
    return 4'd5 + {2'b00, wlen};
  endfunction

endpackage

// File: rtl/gh_shift_reg_pl_so.sv
// Parallel-load, shift-enable register; serial output is bit 0 (LSB first).
module gh_shift_reg_pl_so #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         srst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         q
);

  logic [W-1:0] data_reg;
  logic [W-1:0] data_next;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      if (gi == W - 1) begin : g_top
        assign data_next[gi] = load ? d[gi] : (shift ? 1'b0 : data_reg[gi]);
      end else begin : g_low
        assign data_next[gi] = load ? d[gi] : (shift ? data_reg[gi+1] : data_reg[gi]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
    end else if (srst) begin
      data_reg <= '0;
    end else begin
      data_reg <= data_next;
    end
  end

  assign q = data_reg[0];

endmodule

// File: rtl/gh_uart_tx_serializer.sv
// UART transmit serializer: one character per handshake, sent as start, 5-8 data
// bits LSB first, optional parity and 1/1.5/2 stop bits, timed by an oversampled enable.
module gh_uart_tx_serializer
  import gh_uart_pkg::*;
#(
  parameter int MAX_BITS   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                srst,
  input  logic                brc,
  input  logic                d_valid,
  output logic                d_ready,
  input  logic [MAX_BITS-1:0] d,
  input  logic [1:0]          wlen,
  input  logic                parity_en,
  input  logic                parity_even,
  input  logic                stop2,
  input  logic                brk,
  output logic                tx,
  output logic                busy
);

  localparam int TW = $clog2(2 * OVERSAMPLE);
  localparam logic [TW-1:0] BIT_LAST    = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP2_LAST  = TW'(2 * OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP15_LAST = TW'(3 * OVERSAMPLE / 2 - 1);

  tx_state_t     state_reg;
  logic [TW-1:0] tick_reg;
  logic [3:0]    bit_cnt_reg;
  logic [3:0]    nbits_reg;
  logic          par_en_reg;
  logic          par_bit_reg;
  logic          stop2_reg;
  logic          line_reg;

  logic [3:0]          acc_bits;
  logic [MAX_BITS-1:0] valid_mask;
  logic                parity_calc;
  logic [TW-1:0]       tick_last;
  logic                period_done;
  logic                last_bit;
  logic                accept;
  logic                shift_en;
  logic                sout;

  assign acc_bits = wlen_to_bits(wlen);

  // Parity only covers the bits that will actually be sent.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_BITS; gi++) begin : g_mask
      assign valid_mask[gi] = (acc_bits > 4'(gi));
    end
  endgenerate

  assign parity_calc = parity_even ? ^(d & valid_mask) : ~^(d & valid_mask);

  assign tick_last = (state_reg == STOP && stop2_reg)
                   ? ((nbits_reg == 4'd5) ? STOP15_LAST : STOP2_LAST)
                   : BIT_LAST;
  assign period_done = brc & (tick_reg == tick_last);
  assign last_bit    = (bit_cnt_reg == nbits_reg - 4'd1);

  assign d_ready  = (state_reg == IDLE) & ~srst;
  assign accept   = d_valid & d_ready;
  assign shift_en = period_done & ((state_reg == START) | ((state_reg == DATA) & ~last_bit));

  gh_shift_reg_pl_so #(.W(MAX_BITS)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .srst  (srst),
    .load  (accept),
    .shift (shift_en),
    .d     (d),
    .q     (sout)
  );

  // line_reg is the FSM-driven level; tx follows it one-for-one unless brk masks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_cnt_reg <= '0;
      nbits_reg   <= 4'd5;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      stop2_reg   <= 1'b0;
      line_reg    <= 1'b1;
      tx          <= 1'b1;
      busy        <= 1'b0;
    end else if (srst) begin
      state_reg   <= IDLE;
      tick_reg    <= '0;
      bit_cnt_reg <= '0;
      nbits_reg   <= 4'd5;
      par_en_reg  <= 1'b0;
      par_bit_reg <= 1'b0;
      stop2_reg   <= 1'b0;
      line_reg    <= 1'b1;
      tx          <= 1'b1;
      busy        <= 1'b0;
    end else begin
      tx <= ~brk & line_reg;
      if (state_reg != IDLE && brc) begin
        tick_reg <= period_done ? '0 : tick_reg + 1'b1;
      end
      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_reg   <= START;
            tick_reg    <= '0;
            nbits_reg   <= acc_bits;
            par_en_reg  <= parity_en;
            par_bit_reg <= parity_calc;
            stop2_reg   <= stop2;
            line_reg    <= 1'b0;
            tx          <= 1'b0;
            busy        <= 1'b1;
          end
        end
        START: begin
          if (period_done) begin
            state_reg <= DATA;
            line_reg  <= sout;
            tx        <= ~brk & sout;
          end
        end
        DATA: begin
          if (period_done) begin
            if (last_bit) begin
              bit_cnt_reg <= '0;
              if (par_en_reg) begin
                state_reg <= PARITY;
                line_reg  <= par_bit_reg;
                tx        <= ~brk & par_bit_reg;
              end else begin
                state_reg <= STOP;
                line_reg  <= 1'b1;
                tx        <= ~brk;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
              line_reg    <= sout;
              tx          <= ~brk & sout;
            end
          end
        end
        PARITY: begin
          if (period_done) begin
            state_reg <= STOP;
            line_reg  <= 1'b1;
            tx        <= ~brk;
          end
        end
        STOP: begin
          if (period_done) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gh_uart_tx_serializer.sv
// Bench for gh_uart_tx_serializer: table-driven frames, corner sequences and
// randomized frames checked against a slot-based line model.
module tb_gh_uart_tx_serializer;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       srst = 1'b0;
  logic       brc = 1'b0;
  logic       d_valid = 1'b0;
  logic       d_ready;
  logic [7:0] d = '0;
  logic [1:0] wlen = '0;
  logic       parity_en = 1'b0;
  logic       parity_even = 1'b0;
  logic       stop2 = 1'b0;
  logic       brk = 1'b0;
  logic       tx;
  logic       busy;

  int total = 0;
  int bad = 0;
  bit trace[$];

  gh_uart_tx_serializer #(.MAX_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk         (clk),
    .rst         (rst),
    .srst        (srst),
    .brc         (brc),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d           (d),
    .wlen        (wlen),
    .parity_en   (parity_en),
    .parity_even (parity_even),
    .stop2       (stop2),
    .brk         (brk),
    .tx          (tx),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] d;
    logic [1:0] wlen;
    bit         pe;
    bit         pev;
    bit         s2;
    int         exp_len;
    int         exp_ones;
    int         exp_par;   // -1: no parity slot
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Frame length in brc pulses: start + data + parity slots, then the stop time.
  function automatic int frame_pulses(input int nb, input bit pe, input bit s2);
    int stop_p;
    stop_p = !s2 ? OS : ((nb == 5) ? (OS * 3) / 2 : 2 * OS);
    return OS * (1 + nb + (pe ? 1 : 0)) + stop_p;
  endfunction

  // Line level after p counted pulses, from the bit slot p falls into.
  function automatic bit level_at(input int p, input logic [7:0] dd, input int nb,
                                  input bit pe, input bit pev);
    int slot;
    bit par;
    slot = p / OS;
    if (slot == 0) return 1'b0;
    if (slot <= nb) return dd[slot-1];
    if (pe && slot == nb + 1) begin
      par = 1'b0;
      for (int i = 0; i < nb; i++) par ^= dd[i];
      return pev ? par : !par;
    end
    return 1'b1;
  endfunction

  // Sends one frame from idle and checks tx/busy/d_ready every clk against the model.
  // trace[k] is tx sampled k clks after the accepting edge.
  task automatic run_frame(input string name, input logic [7:0] fd, input logic [1:0] fw,
                           input bit fpe, input bit fpev, input bit fs2, input int brc_pct,
                           input int brk_from, input int brk_to, output int len_clk);
    int nb, tot, p, k, errs, first;
    bit brk_prev, exp_tx, exp_busy;
    logic f_tx, f_busy, f_rdy;
    bit w_tx, w_busy;
    nb = int'(fw) + 5;
    tot = frame_pulses(nb, fpe, fs2);
    p = 0; k = 0; errs = 0; first = -1;
    brk_prev = 1'b0;
    f_tx = 1'b0; f_busy = 1'b0; f_rdy = 1'b0; w_tx = 1'b0; w_busy = 1'b0;
    trace.delete();
    check({name, " ready before accept"}, int'(d_ready), 1);
    d = fd; wlen = fw; parity_en = fpe; parity_even = fpev; stop2 = fs2;
    d_valid = 1'b1; brk = 1'b0;
    brc = ($urandom_range(99) < brc_pct);
    step();
    forever begin
      exp_busy = (p < tot);
      exp_tx = brk_prev ? 1'b0 : (exp_busy ? level_at(p, fd, nb, fpe, fpev) : 1'b1);
      trace.push_back(tx);
      if (tx !== exp_tx || busy !== exp_busy || d_ready !== !exp_busy) begin
        errs++;
        if (first < 0) begin
          first = k; f_tx = tx; f_busy = busy; f_rdy = d_ready; w_tx = exp_tx; w_busy = exp_busy;
        end
      end
      if (!exp_busy || k >= 5000) break;
      // Inputs other than brc/brk are scrambled: they must not matter mid-frame.
      d_valid = 1'($urandom);
      d = 8'($urandom);
      wlen = 2'($urandom);
      parity_en = 1'($urandom);
      parity_even = 1'($urandom);
      stop2 = 1'($urandom);
      brc = ($urandom_range(99) < brc_pct);
      brk = (k + 1 >= brk_from && k + 1 < brk_to);
      brk_prev = brk;
      step();
      if (brc) p++;
      k++;
    end
    d_valid = 1'b0; brc = 1'b0; brk = 1'b0;
    len_clk = k;
    total++;
    if (errs != 0 || p < tot) begin
      bad++;
      $display("FAIL frame %s: %0d bad clks, first at clk %0d tx=%b busy=%b rdy=%b want tx=%b busy=%b rdy=%b, pulses %0d of %0d",
               name, errs, first, f_tx, f_busy, f_rdy, w_tx, w_busy, !w_busy, p, tot);
    end
    $display("frame %s d=%02h bits=%0d pe=%0d even=%0d stop2=%0d clks=%0d", name, fd, nb, fpe, fpev, fs2, len_clk);
  endtask

  initial begin
    int len, nb, ones, rdy_first, rdy_cnt, start2;
    logic [7:0] b1, b2;

    vecs[0] = '{"8N1 55",  8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 160, 4, -1};
    vecs[1] = '{"7E2 41",  8'h41, 2'b10, 1'b1, 1'b1, 1'b1, 176, 2, 0};
    vecs[2] = '{"7O2 41",  8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 176, 2, 1};
    vecs[3] = '{"5N2 FF",  8'hFF, 2'b00, 1'b0, 1'b0, 1'b1, 120, 5, -1};
    vecs[4] = '{"6O1 2C",  8'h2C, 2'b01, 1'b1, 1'b0, 1'b0, 144, 3, 0};
    vecs[5] = '{"8E1 FF",  8'hFF, 2'b11, 1'b1, 1'b1, 1'b0, 176, 8, 0};
    vecs[6] = '{"8N2 00",  8'h00, 2'b11, 1'b0, 1'b0, 1'b1, 176, 0, -1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset tx", int'(tx), 1);
    check("reset busy", int'(busy), 0);
    step();
    check("reset ready", int'(d_ready), 1);

    foreach (vecs[i]) begin
      run_frame(vecs[i].name, vecs[i].d, vecs[i].wlen, vecs[i].pe, vecs[i].pev, vecs[i].s2,
                100, 0, 0, len);
      nb = int'(vecs[i].wlen) + 5;
      check({vecs[i].name, " length"}, len, vecs[i].exp_len);
      ones = 0;
      for (int j = 0; j < nb; j++) ones += int'(trace[OS * (j + 1) + OS / 2]);
      check({vecs[i].name, " data ones"}, ones, vecs[i].exp_ones);
      if (vecs[i].exp_par >= 0)
        check({vecs[i].name, " parity"}, int'(trace[OS * (nb + 1) + OS / 2]), vecs[i].exp_par);
    end

    // Back-to-back: d_valid held, second frame must start one clk after the first stop.
    d = 8'hA5; wlen = 2'b11; parity_en = 1'b0; stop2 = 1'b0; brc = 1'b1; d_valid = 1'b1;
    step();
    d = 8'h3C;
    rdy_first = -1; rdy_cnt = 0; start2 = -1;
    trace.delete();
    for (int k = 0; k < 321; k++) begin
      trace.push_back(tx);
      if (d_ready === 1'b1) begin
        rdy_cnt++;
        if (rdy_first < 0) rdy_first = k;
      end
      if (k > 160 && start2 < 0 && tx === 1'b0) start2 = k;
      if (k == 161) d_valid = 1'b0;
      step();
    end
    brc = 1'b0;
    b1 = '0; b2 = '0;
    for (int j = 0; j < 8; j++) begin
      b1[j] = trace[OS * (j + 1) + OS / 2];
      b2[j] = trace[161 + OS * (j + 1) + OS / 2];
    end
    check("b2b ready first clk", rdy_first, 160);
    check("b2b ready pulse width", rdy_cnt, 1);
    check("b2b second start clk", start2, 161);
    check("b2b first byte", int'(b1), 8'hA5);
    check("b2b second byte", int'(b2), 8'h3C);
    $display("frame b2b A5/3C ready_at=%0d start2=%0d", rdy_first, start2);

    // Asynchronous reset during data bit 3.
    d = 8'h00; wlen = 2'b11; parity_en = 1'b0; stop2 = 1'b0; brc = 1'b1; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    repeat (72) step();
    check("rst pre tx", int'(tx), 0);
    rst = 1'b1;
    #1;
    check("rst async tx", int'(tx), 1);
    check("rst async busy", int'(busy), 0);
    step();
    rst = 1'b0;
    step();
    check("rst ready after release", int'(d_ready), 1);
    $display("frame abort by rst");

    // Synchronous clear during data bit 3.
    d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    repeat (72) step();
    srst = 1'b1;
    #1;
    check("srst no async effect", int'(tx), 0);
    step();
    check("srst tx", int'(tx), 1);
    check("srst busy", int'(busy), 0);
    check("srst masks ready", int'(d_ready), 0);
    srst = 1'b0;
    #1;
    check("srst ready after release", int'(d_ready), 1);
    brc = 1'b0;
    $display("frame abort by srst");
    run_frame("after srst 8E1 5A", 8'h5A, 2'b11, 1'b1, 1'b1, 1'b0, 100, 0, 0, len);
    check("after srst length", len, 176);

    // Break asserted mid-data, released during stop.
    run_frame("break 8N1 FF", 8'hFF, 2'b11, 1'b0, 1'b0, 1'b0, 100, 40, 150, len);
    check("break length", len, 160);
    check("break before", int'(trace[39]), 1);
    check("break low", int'(trace[40]), 0);
    check("break last low", int'(trace[149]), 0);
    check("break released", int'(trace[150]), 1);

    // Randomized frames with sparse brc and occasional break windows.
    for (int i = 0; i < 12; i++) begin
      int bf, bt;
      bf = 0; bt = 0;
      if ($urandom_range(3) == 0) begin
        bf = int'($urandom_range(100, 1));
        bt = bf + int'($urandom_range(60, 1));
      end
      run_frame($sformatf("rand%0d", i), 8'($urandom), 2'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), int'($urandom_range(100, 40)), bf, bt, len);
      repeat ($urandom_range(3)) step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gh_uart_tx_serializer.md
Name: gh_uart_tx_serializer

Overview:
- UART transmit serializer: accepts one parallel character per valid/ready handshake and shifts it out LSB first as a standard async frame (start, 5-8 data bits, optional parity, stop).
- It is the transmit counterpart of the receive-side serial-in shift register. It sits between the TX holding FIFO and the sTX pin.
- Bit timing is derived from a one-clk-wide baud-rate enable running at OVERSAMPLE x baud.

Parameters:
- MAX_BITS, 8, widest supported data word; d port width.
- OVERSAMPLE, 16, baud-enable pulses per bit period; must be even and >= 4.

Ports:
- clk  input  1  system clock
- rst  input  1  reset: asynchronous, active-high
- srst  input  1  synchronous clear, active-high
- brc  input  1  baud enable, one clk wide, OVERSAMPLE x baud
- d_valid  input  1  character available
- d_ready  output  1  serializer can accept a character
- d  input  MAX_BITS  character; bit 0 is sent first
- wlen  input  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- parity_en  input  1  insert parity bit
- parity_even  input  1  1=even parity, 0=odd
- stop2  input  1  0=1 stop bit; 1=2 stop bits (1.5 when wlen=00)
- brk  input  1  break: force line low
- tx  output  1  serial line, idle high
- busy  output  1  frame in progress

Behaviour:
- Reset (rst or srst): state IDLE, tx=1, busy=0, tick and bit counters=0. d_ready is 1 from the first clk after reset release. srst has the same effect synchronously, and an abort mid-frame returns tx to 1 on the next clk.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- d_ready = (state==IDLE) & ~srst.
- Accept occurs on d_valid & d_ready. On that edge the serializer:
  - latches d, wlen, parity_en, parity_even and stop2;
  - clears the tick counter;
  - enters START.
- Input changes after accept have no effect until the next accept.
- tx is registered. It falls on the clk edge that accepts the character (latency 1 clk from the handshake cycle).
- Tick counter increments on each brc pulse. A brc pulse in the accept cycle is not counted.
- Bit period = OVERSAMPLE brc pulses. On the pulse that completes a period, the next bit is driven on that same edge.
- DATA sends wlen+5 bits LSB first from a right-shifting register. The bit counter wraps to 0 on exit.
- PARITY is entered only if parity_en=1.
  - Parity bit = XOR of the latched valid data bits when even, XNOR when odd.
  - Bits above wlen+5 are excluded.
- STOP drives tx=1 for:
  - OVERSAMPLE pulses when stop2=0;
  - 2*OVERSAMPLE pulses when stop2=1 and wlen!=00;
  - 3*OVERSAMPLE/2 pulses when stop2=1 and wlen=00.
- On STOP completion the state returns to IDLE and d_ready=1 on the next cycle. Back-to-back frames therefore have at least one clk of idle-high.
- busy = (state!=IDLE).
- brk=1: tx is driven 0 from the next clk edge for as long as brk is held. The FSM and counters keep running unaffected. When brk falls, tx resumes the FSM-driven value on the next edge.
- Without brc pulses the FSM holds its state indefinitely. There is no timeout.
- d_valid while busy is ignored; no overrun flag is generated.

Decomposition:
- Package gh_uart_pkg holds:
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - wlen encoding constants WLEN_5..WLEN_8;
  - function wlen_to_bits().
- One sub-module: gh_shift_reg_pl_so, a parallel-load, shift-enable, LSB-first serial-out register with async rst and srst. It holds the data word.

Test Plan:
- 8N1, d=0x55, brc every clk, OVERSAMPLE=16. Expected:
  - tx=0 for 16 clk;
  - then 1,0,1,0,1,0,1,0 at 16 clk each;
  - then 1 for 16 clk;
  - busy low 1 clk after stop ends; total frame 160 clk.
- 7E2, d=0x41 (bits 1000001, two ones). Expected: parity bit 0, stop high for 32 brc. With 7O2 the parity bit is 1.
- 5-bit, stop2=1, d=0x1F with upper bits set to 0xFF. Expected: only 5 ones are sent, and the stop bit lasts 24 brc.
- Back-to-back: d_valid held high with 0xA5 then 0x3C. Expected: second frame starts exactly 1 clk after the first STOP ends, and d_ready pulses for 1 clk.
- Reset mid-frame: assert rst during DATA bit 3. Expected: tx=1 and busy=0 asynchronously. Repeat with srst: tx=1 on the next clk and a new frame is accepted normally.
- Break: brk=1 during DATA. Expected: tx=0 next clk while the FSM completes on schedule. Release brk during STOP: tx=1 next clk.
